// File: rtl/bist_response_analyzer_pkg.sv
// bist_pkg: shared types and helpers for the 6:3 counter BIST response path.
// FSM state enum, default MISR constants, and the popcount6 golden model.
package bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } bist_state_e;

   localparam logic [7:0] BIST_MISR_POLY = 8'h1D;
   localparam logic [7:0] BIST_MISR_SEED = 8'h00;

   function automatic logic [2:0] popcount6(input logic [5:0] v);
      logic [2:0] c;
      c = '0;
      for (int i = 0; i < 6; i++) begin
         c = c + {2'b00, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/bist_response_analyzer_misr.sv
// bist_misr: multiple-input signature register, shift-left with XOR feedback.
// Load reseeds at run start; enable folds one input word per cycle.
module bist_misr #(
   parameter int           W    = 8,
   parameter logic [W-1:0] POLY = W'(8'h1D),
   parameter logic [W-1:0] SEED = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic         i_en,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_sig
);

   logic [W-1:0] r_sig;
   logic [W-1:0] w_next;

   // next signature: shift, conditional polynomial feedback, fold input
   always_comb begin
      w_next = {r_sig[W-2:0], 1'b0}
             ^ (r_sig[W-1] ? POLY : '0)
             ^ i_data;
   end

   // signature register; reseed on reset or load
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sig <= SEED;
      end else if (i_load) begin
         r_sig <= SEED;
      end else if (i_en) begin
         r_sig <= w_next;
      end
   end

   assign o_sig = r_sig;

endmodule

// File: rtl/bist_response_analyzer.sv
// bist_response_analyzer: checks 6:3 counter results against popcount.
// Optional MISR compaction enabled by defining BIST_RESP_MISR_EN.
module bist_response_analyzer
   import bist_pkg::*;
#(
   parameter int                NUM_PATTERNS = 64,
   parameter int                ERR_CNT_W    = 8,
   parameter int                MISR_W       = 8,
   parameter logic [MISR_W-1:0] MISR_POLY    = MISR_W'(BIST_MISR_POLY),
   parameter logic [MISR_W-1:0] MISR_SEED    = MISR_W'(BIST_MISR_SEED),
   localparam int               CNT_W        = $clog2(NUM_PATTERNS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 pat_valid,
   input  logic [5:0]           pat,
   input  logic [2:0]           cut_o,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0]     first_fail_idx,
   output logic                 fail_seen,
   output logic [MISR_W-1:0]    signature
);

   bist_state_e          r_state;
   logic [CNT_W-1:0]     r_pat_cnt;
   logic [CNT_W-1:0]     r_ffi;
   logic [ERR_CNT_W-1:0] r_err;
   logic                 r_fs;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_pass;

   logic [2:0]           w_golden;
   logic                 w_mismatch;
   logic                 w_accept;
   logic                 w_last;
   logic [ERR_CNT_W-1:0] w_err_nxt;

   // golden compare and saturating error increment
   always_comb begin
      w_golden   = popcount6(pat);
      w_mismatch = (cut_o != w_golden);
      w_accept   = (r_state == ST_RUN) && pat_valid && !abort;
      w_last     = (r_pat_cnt == CNT_W'(NUM_PATTERNS - 1));
      w_err_nxt  = r_err;
      if (w_mismatch && !(&r_err)) begin
         w_err_nxt = r_err + 1'b1;
      end
   end

   // run control FSM with registered status outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_pat_cnt <= '0;
         r_err     <= '0;
         r_ffi     <= '0;
         r_fs      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_state   <= ST_RUN;
                  r_pat_cnt <= '0;
                  r_err     <= '0;
                  r_ffi     <= '0;
                  r_fs      <= 1'b0;
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
                  r_pass    <= 1'b0;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
                  r_pass  <= 1'b0;
               end else if (w_accept) begin
                  r_err     <= w_err_nxt;
                  r_pat_cnt <= r_pat_cnt + 1'b1;
                  if (w_mismatch && !r_fs) begin
                     r_ffi <= r_pat_cnt;
                     r_fs  <= 1'b1;
                  end
                  if (w_last) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_pass  <= (w_err_nxt == '0);
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_pass  <= 1'b0;
            end
         endcase
      end
   end

   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign err_cnt        = r_err;
   assign first_fail_idx = r_ffi;
   assign fail_seen      = r_fs;

`ifdef BIST_RESP_MISR_EN
   logic w_load;
   assign w_load = start && (r_state != ST_RUN);

   bist_misr #(
      .W    (MISR_W),
      .POLY (MISR_POLY),
      .SEED (MISR_SEED)
   ) u_misr (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load),
      .i_en   (w_accept),
      .i_data ({{(MISR_W-3){1'b0}}, cut_o}),
      .o_sig  (signature)
   );
`else
   assign signature = '0;
`endif

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Directed bench for bist_response_analyzer (NUM_PATTERNS=4, ERR_CNT_W=2).
// Vector table for run sequences plus hand sequences for reset and MISR.
module tb_bist_response_analyzer;

   localparam int NP  = 4;
   localparam int EW  = 2;
   localparam int MW  = 8;
   localparam int CW  = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          abort;
   logic          pat_valid;
   logic [5:0]    pat;
   logic [2:0]    cut_o;
   logic          busy;
   logic          done;
   logic          pass;
   logic [EW-1:0] err_cnt;
   logic [CW-1:0] first_fail_idx;
   logic          fail_seen;
   logic [MW-1:0] signature;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bist_response_analyzer #(
      .NUM_PATTERNS (NP),
      .ERR_CNT_W    (EW),
      .MISR_W       (MW),
      .MISR_POLY    (8'h1D),
      .MISR_SEED    (8'h00)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .abort          (abort),
      .pat_valid      (pat_valid),
      .pat            (pat),
      .cut_o          (cut_o),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_cnt        (err_cnt),
      .first_fail_idx (first_fail_idx),
      .fail_seen      (fail_seen),
      .signature      (signature)
   );

   typedef struct {
      logic       st;
      logic       ab;
      logic       v;
      logic [5:0] p;
      logic [2:0] c;
      logic       e_busy;
      logic       e_done;
      logic       e_pass;
      int         e_err;
      logic       e_fs;
      int         e_ffi;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic st, input logic ab,
                               input logic v, input logic [5:0] p,
                               input logic [2:0] c, input logic b,
                               input logic d, input logic ps,
                               input int er, input logic fs,
                               input int ffi);
      vec_t r;
      r.st = st; r.ab = ab; r.v = v; r.p = p; r.c = c;
      r.e_busy = b; r.e_done = d; r.e_pass = ps;
      r.e_err = er; r.e_fs = fs; r.e_ffi = ffi;
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic ab, input logic v,
                        input logic [5:0] p, input logic [2:0] c);
      start = st; abort = ab; pat_valid = v; pat = p; cut_o = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(0, 0, 0, 6'd0, 3'd0);
      reset = 1'b0;
      @(negedge clk);

      // reset state
      tick();
      @(negedge clk);
      tick();
      chk("rst0_busy", busy, 0);
      chk("rst0_done", done, 0);
      chk("rst0_pass", pass, 0);
      chk("rst0_err", err_cnt, 0);
      chk("rst0_fs", fail_seen, 0);
      chk("rst0_sig", signature, 8'h00);
      @(negedge clk);
      reset = 1'b1;

      // mid-run reset after 3 errors
      drive(1, 0, 0, 6'd0, 3'd0);
      tick(); @(negedge clk);
      drive(0, 0, 1, 6'b000000, 3'd1);
      tick(); @(negedge clk);
      drive(0, 0, 1, 6'b111111, 3'd1);
      tick(); @(negedge clk);
      drive(0, 0, 1, 6'b101010, 3'd1);
      tick();
      chk("pre_rst_err", err_cnt, 3);
      chk("pre_rst_busy", busy, 1);
      @(negedge clk);
      drive(0, 0, 0, 6'd0, 3'd0);
      reset = 1'b0;
      tick(); @(negedge clk);
      tick();
      chk("rst1_err", err_cnt, 0);
      chk("rst1_fs", fail_seen, 0);
      chk("rst1_busy", busy, 0);
      chk("rst1_done", done, 0);
      chk("rst1_sig", signature, 8'h00);
      @(negedge clk);
      reset = 1'b1;

      // clean run
      tbl.push_back(mk(1,0,0,6'b000000,0, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,1,6'b000000,0, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,1,6'b111111,6, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,1,6'b101010,3, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,1,6'b000111,3, 0,1,1, 0,0,0));
      // abort ignored in DONE
      tbl.push_back(mk(0,1,0,6'b000000,0, 0,1,1, 0,0,0));
      // fault on pattern 1
      tbl.push_back(mk(1,0,0,6'b000000,0, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,1,6'b000000,0, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,1,6'b111111,5, 1,0,0, 1,1,1));
      tbl.push_back(mk(0,0,1,6'b101010,3, 1,0,0, 1,1,1));
      tbl.push_back(mk(0,0,1,6'b000111,3, 0,1,0, 1,1,1));
      // all wrong with stalls, saturating
      tbl.push_back(mk(1,0,0,6'b000000,0, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,1,6'b000000,1, 1,0,0, 1,1,0));
      tbl.push_back(mk(0,0,0,6'b111111,0, 1,0,0, 1,1,0));
      tbl.push_back(mk(0,0,1,6'b111111,0, 1,0,0, 2,1,0));
      tbl.push_back(mk(0,0,0,6'b101010,0, 1,0,0, 2,1,0));
      tbl.push_back(mk(0,0,1,6'b101010,0, 1,0,0, 3,1,0));
      tbl.push_back(mk(0,0,0,6'b000111,0, 1,0,0, 3,1,0));
      tbl.push_back(mk(0,0,1,6'b000111,0, 0,1,0, 3,1,0));
      // abort after 2 patterns, then clean restart
      tbl.push_back(mk(1,0,0,6'b000000,0, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,1,6'b000000,1, 1,0,0, 1,1,0));
      tbl.push_back(mk(0,0,1,6'b111111,6, 1,0,0, 1,1,0));
      tbl.push_back(mk(0,1,1,6'b101010,0, 0,0,0, 1,1,0));
      tbl.push_back(mk(0,1,0,6'b000000,0, 0,0,0, 1,1,0));
      tbl.push_back(mk(1,0,0,6'b000000,0, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,1,6'b000000,0, 1,0,0, 0,0,0));
      tbl.push_back(mk(1,0,1,6'b111111,6, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,1,6'b101010,3, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,1,6'b000111,3, 0,1,1, 0,0,0));
      // abort beats an accepted last pattern
      tbl.push_back(mk(1,0,0,6'b000000,0, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,1,6'b000000,0, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,1,6'b111111,6, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,0,1,6'b101010,3, 1,0,0, 0,0,0));
      tbl.push_back(mk(0,1,1,6'b000111,0, 0,0,0, 0,0,0));

      foreach (tbl[i]) begin
         drive(tbl[i].st, tbl[i].ab, tbl[i].v, tbl[i].p, tbl[i].c);
         tick();
         chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
         chk($sformatf("v%0d_done", i), done, tbl[i].e_done);
         chk($sformatf("v%0d_pass", i), pass, tbl[i].e_pass);
         chk($sformatf("v%0d_err", i), err_cnt, tbl[i].e_err);
         chk($sformatf("v%0d_fs", i), fail_seen, tbl[i].e_fs);
         chk($sformatf("v%0d_ffi", i), first_fail_idx, tbl[i].e_ffi);
         @(negedge clk);
      end

      // MISR: cut_o 1,2,3 gives 01,00,03 from seed 0
      drive(1, 0, 0, 6'd0, 3'd0);
      tick();
      chk("misr_seed", signature, 8'h00);
      @(negedge clk);
      drive(0, 0, 1, 6'b000001, 3'd1);
      tick();
`ifdef BIST_RESP_MISR_EN
      chk("misr_1", signature, 8'h01);
`else
      chk("misr_1", signature, 8'h00);
`endif
      @(negedge clk);
      drive(0, 0, 1, 6'b000011, 3'd2);
      tick();
      chk("misr_2", signature, 8'h00);
      @(negedge clk);
      drive(0, 0, 1, 6'b000111, 3'd3);
      tick();
`ifdef BIST_RESP_MISR_EN
      chk("misr_3", signature, 8'h03);
`else
      chk("misr_3", signature, 8'h00);
`endif
      chk("misr_busy", busy, 1);
      @(negedge clk);
      drive(0, 0, 0, 6'd0, 3'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
